// File: rtl/fp_vector_checker_pkg.sv
// Shared types for the fp_unit regression checker: FP op select, checker state, canonical NaN.
package fp_vector_checker_pkg;

  localparam int unsigned FP_MAX_XLEN = 64;

  // One-hot operation select presented to the FP execution port
  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fcvt_f2i;
    logic       fcvt_i2f;
    logic       fmv_f2i;
    logic       fmv_i2f;
    logic       fclass;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef enum logic [1:0] {
    CHK_RUN   = 2'd0,
    CHK_DRAIN = 2'd1,
    CHK_DONE  = 2'd2,
    CHK_HALT  = 2'd3
  } fp_chk_state_type;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set
  function automatic logic [FP_MAX_XLEN-1:0] canonical_nan(input int unsigned exp_w,
                                                           input int unsigned man_w);
    logic [FP_MAX_XLEN-1:0] exp_ones;
    exp_ones = (FP_MAX_XLEN'(1) << exp_w) - FP_MAX_XLEN'(1);
    return (exp_ones << man_w) | (FP_MAX_XLEN'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_chk_fifo.sv
// In-order store of issued-but-unchecked expectations; flush empties it synchronously.
module fp_chk_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign head_c  = mem[rd_ptr];

  // Entry storage, written on accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fp_vector_checker.sv
// Stimulus/response scoreboard: issues reference vectors to the FP port and checks results in order.
module fp_vector_checker
  import fp_vector_checker_pkg::*;
#(
  parameter int unsigned EXP_W        = 8,
  parameter int unsigned MAN_W        = 23,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 32,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   vec_valid,
  output logic                   vec_ready,
  input  logic                   vec_last,
  input  logic [EXP_W+MAN_W:0]   vec_data1,
  input  logic [EXP_W+MAN_W:0]   vec_data2,
  input  logic [EXP_W+MAN_W:0]   vec_data3,
  input  logic [2:0]             vec_rm,
  input  fp_operation_type       vec_op,
  input  logic [EXP_W+MAN_W:0]   vec_result,
  input  logic [4:0]             vec_flags,
  output logic [EXP_W+MAN_W:0]   dut_data1,
  output logic [EXP_W+MAN_W:0]   dut_data2,
  output logic [EXP_W+MAN_W:0]   dut_data3,
  output logic [2:0]             dut_rm,
  output logic [1:0]             dut_fmt,
  output fp_operation_type       dut_op,
  output logic                   dut_enable,
  output logic                   dut_clear,
  input  logic [EXP_W+MAN_W:0]   dut_result,
  input  logic [4:0]             dut_flags,
  input  logic                   dut_ready,
  output logic                   done,
  output logic                   fail,
  output logic                   proto_err,
  output logic [CNT_W-1:0]       pass_count,
  output logic [CNT_W-1:0]       fail_count,
  output logic [EXP_W+MAN_W:0]   err_a,
  output logic [EXP_W+MAN_W:0]   err_b,
  output logic [EXP_W+MAN_W:0]   err_c,
  output logic [EXP_W+MAN_W:0]   err_ref,
  output logic [EXP_W+MAN_W:0]   err_calc,
  output logic [4:0]             err_fref,
  output logic [4:0]             err_fcalc
);

  localparam int unsigned XLEN = 1 + EXP_W + MAN_W;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] CNAN = XLEN'(canonical_nan(EXP_W, MAN_W));

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] data3;
    logic [XLEN-1:0] result;
    logic [4:0]      flags;
  } fp_chk_entry_type;

  localparam int unsigned ENTRY_W = $bits(fp_chk_entry_type);

  fp_chk_state_type  state;
  fp_chk_state_type  state_next;
  fp_chk_entry_type  push_entry;
  fp_chk_entry_type  head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              accept;
  logic              check;
  logic              pop;
  logic              match;
  logic              hit_pass;
  logic              hit_fail;
  logic [XLEN-1:0]   diff;

  assign dut_fmt    = 2'b00;
  assign fifo_empty = (fifo_count == '0);
  assign vec_ready  = (state == CHK_RUN) & (fifo_count != CW'(DEPTH)) & ~clear;
  assign accept     = vec_valid & vec_ready;
  assign check      = dut_ready & (state != CHK_HALT) & ~clear;
  assign pop        = check & ~fifo_empty;
  assign head       = fp_chk_entry_type'(head_bits);

  assign push_entry = '{data1: vec_data1, data2: vec_data2, data3: vec_data3,
                        result: vec_result, flags: vec_flags};

  fp_chk_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head_c    (head_bits),
    .count     (fifo_count)
  );

  // Result compare; a canonical-NaN result only has to match exponent and mantissa MSB
  always_comb begin
    diff = head.result ^ dut_result;
    if (dut_result == CNAN) diff = diff & CNAN;
    match    = (diff == '0) && ((head.flags ^ dut_flags) == '0);
    hit_pass = pop & match;
    hit_fail = check & (fifo_empty | ~match);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= CHK_RUN;
    else        state <= state_next;
  end

  // Next-state: issue, drain after the last vector, halt on mismatch, clear wins over all
  always_comb begin
    state_next = state;
    case (state)
      CHK_RUN:   if (accept && vec_last) state_next = CHK_DRAIN;
      CHK_DRAIN: if (fifo_empty) state_next = CHK_DONE;
      default:   state_next = state;
    endcase
    if (STOP_ON_FAIL && hit_fail) state_next = CHK_HALT;
    if (clear) state_next = CHK_RUN;
  end

  // Issue port, status, counters and first-failure capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dut_data1  <= '0;
      dut_data2  <= '0;
      dut_data3  <= '0;
      dut_rm     <= '0;
      dut_op     <= init_fp_operation;
      dut_enable <= 1'b0;
      dut_clear  <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      proto_err  <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      err_a      <= '0;
      err_b      <= '0;
      err_c      <= '0;
      err_ref    <= '0;
      err_calc   <= '0;
      err_fref   <= '0;
      err_fcalc  <= '0;
    end else begin
      dut_enable <= accept;
      dut_clear  <= clear;
      done       <= (state_next == CHK_DONE);
      if (accept) begin
        dut_data1 <= vec_data1;
        dut_data2 <= vec_data2;
        dut_data3 <= vec_data3;
        dut_rm    <= vec_rm;
        dut_op    <= vec_op;
      end else begin
        dut_op    <= init_fp_operation;
      end
      if (clear) begin
        fail       <= 1'b0;
        proto_err  <= 1'b0;
        pass_count <= '0;
        fail_count <= '0;
        err_a      <= '0;
        err_b      <= '0;
        err_c      <= '0;
        err_ref    <= '0;
        err_calc   <= '0;
        err_fref   <= '0;
        err_fcalc  <= '0;
      end else begin
        if (hit_pass && (pass_count != '1)) pass_count <= pass_count + CNT_W'(1);
        if (hit_fail) begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          fail <= 1'b1;
          if (fifo_empty) proto_err <= 1'b1;
          if (!fail) begin
            err_a     <= fifo_empty ? '0 : head.data1;
            err_b     <= fifo_empty ? '0 : head.data2;
            err_c     <= fifo_empty ? '0 : head.data3;
            err_ref   <= fifo_empty ? '0 : head.result;
            err_fref  <= fifo_empty ? '0 : head.flags;
            err_calc  <= dut_result;
            err_fcalc <= dut_flags;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed bench: instance a halts on first mismatch, instance b keeps counting.
module tb_fp_vector_checker;
  import fp_vector_checker_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic             clear = 1'b0;
  logic             vec_valid = 1'b0;
  logic             vec_last = 1'b0;
  logic [31:0]      vec_data1 = '0, vec_data2 = '0, vec_data3 = '0;
  logic [2:0]       vec_rm = '0;
  fp_operation_type vec_op = init_fp_operation;
  logic [31:0]      vec_result = '0;
  logic [4:0]       vec_flags = '0;
  logic [31:0]      dut_result = '0;
  logic [4:0]       dut_flags = '0;
  logic             dut_ready = 1'b0;

  logic             a_vec_ready, b_vec_ready;
  logic [31:0]      a_dut_data1, a_dut_data2, a_dut_data3, b_dut_data1, b_dut_data2, b_dut_data3;
  logic [2:0]       a_dut_rm, b_dut_rm;
  logic [1:0]       a_dut_fmt, b_dut_fmt;
  fp_operation_type a_dut_op, b_dut_op;
  logic             a_dut_enable, b_dut_enable, a_dut_clear, b_dut_clear;
  logic             a_done, b_done, a_fail, b_fail, a_proto_err, b_proto_err;
  logic [31:0]      a_pass_count, a_fail_count, b_pass_count, b_fail_count;
  logic [31:0]      a_err_a, a_err_b, a_err_c, a_err_ref, a_err_calc;
  logic [31:0]      b_err_a, b_err_b, b_err_c, b_err_ref, b_err_calc;
  logic [4:0]       a_err_fref, a_err_fcalc, b_err_fref, b_err_fcalc;

  fp_vector_checker #(.STOP_ON_FAIL(1'b1)) u_a (
    .reset(reset), .clock(clock), .clear(clear),
    .vec_valid(vec_valid), .vec_ready(a_vec_ready), .vec_last(vec_last),
    .vec_data1(vec_data1), .vec_data2(vec_data2), .vec_data3(vec_data3),
    .vec_rm(vec_rm), .vec_op(vec_op), .vec_result(vec_result), .vec_flags(vec_flags),
    .dut_data1(a_dut_data1), .dut_data2(a_dut_data2), .dut_data3(a_dut_data3),
    .dut_rm(a_dut_rm), .dut_fmt(a_dut_fmt), .dut_op(a_dut_op),
    .dut_enable(a_dut_enable), .dut_clear(a_dut_clear),
    .dut_result(dut_result), .dut_flags(dut_flags), .dut_ready(dut_ready),
    .done(a_done), .fail(a_fail), .proto_err(a_proto_err),
    .pass_count(a_pass_count), .fail_count(a_fail_count),
    .err_a(a_err_a), .err_b(a_err_b), .err_c(a_err_c), .err_ref(a_err_ref),
    .err_calc(a_err_calc), .err_fref(a_err_fref), .err_fcalc(a_err_fcalc)
  );

  fp_vector_checker #(.STOP_ON_FAIL(1'b0)) u_b (
    .reset(reset), .clock(clock), .clear(clear),
    .vec_valid(vec_valid), .vec_ready(b_vec_ready), .vec_last(vec_last),
    .vec_data1(vec_data1), .vec_data2(vec_data2), .vec_data3(vec_data3),
    .vec_rm(vec_rm), .vec_op(vec_op), .vec_result(vec_result), .vec_flags(vec_flags),
    .dut_data1(b_dut_data1), .dut_data2(b_dut_data2), .dut_data3(b_dut_data3),
    .dut_rm(b_dut_rm), .dut_fmt(b_dut_fmt), .dut_op(b_dut_op),
    .dut_enable(b_dut_enable), .dut_clear(b_dut_clear),
    .dut_result(dut_result), .dut_flags(dut_flags), .dut_ready(dut_ready),
    .done(b_done), .fail(b_fail), .proto_err(b_proto_err),
    .pass_count(b_pass_count), .fail_count(b_fail_count),
    .err_a(b_err_a), .err_b(b_err_b), .err_c(b_err_c), .err_ref(b_err_ref),
    .err_calc(b_err_calc), .err_fref(b_err_fref), .err_fcalc(b_err_fcalc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Fake FP unit: replays queued responses a fixed latency after each issue strobe
  bit          fpu_on = 1'b0;
  bit          sel_b = 1'b0;
  int          fpu_lat = 3;
  int          cyc = 0;
  logic [31:0] rsp_res[$];
  logic [4:0]  rsp_flg[$];
  int          due_q[$];
  logic [31:0] pr_q[$];
  logic [4:0]  pf_q[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    fpu_on = 1'b0;
    dut_ready = 1'b0;
    rsp_res.delete(); rsp_flg.delete(); due_q.delete(); pr_q.delete(); pf_q.delete();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("dut_clear_pulse", 64'(a_dut_clear), 64'(1));
    step();
  endtask

  task automatic send(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] res, input logic [4:0] flg,
                      input logic [31:0] dres, input logic [4:0] dflg, input bit last);
    int w;
    vec_data1 = d1; vec_data2 = d2; vec_data3 = '0; vec_rm = 3'd0;
    vec_op = init_fp_operation; vec_op.fadd = 1'b1;
    vec_result = res; vec_flags = flg; vec_last = last; vec_valid = 1'b1;
    rsp_res.push_back(dres); rsp_flg.push_back(dflg);
    w = 0;
    while (!(sel_b ? b_vec_ready : a_vec_ready) && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) chk("accept_timeout", 64'(sel_b ? b_vec_ready : a_vec_ready), 64'(1));
    step();
    vec_valid = 1'b0;
    vec_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (!(sel_b ? b_done : a_done) && w < 200) begin
      step();
      w++;
    end
    chk(tag, 64'(sel_b ? b_done : a_done), 64'(1));
  endtask

  initial begin
    int acc;
    int w;
    fork
      forever begin
        step();
        cyc++;
        if (fpu_on) begin
          if (sel_b ? b_dut_enable : a_dut_enable) begin
            due_q.push_back(cyc + fpu_lat - 1);
            pr_q.push_back(rsp_res.size() > 0 ? rsp_res.pop_front() : 32'h0);
            pf_q.push_back(rsp_flg.size() > 0 ? rsp_flg.pop_front() : 5'h0);
          end
          if (due_q.size() > 0 && due_q[0] <= cyc) begin
            dut_ready = 1'b1;
            dut_result = pr_q.pop_front();
            dut_flags = pf_q.pop_front();
            void'(due_q.pop_front());
          end else begin
            dut_ready = 1'b0;
          end
        end
      end
    join_none

    // Reset values
    repeat (3) step();
    chk("rst_dut_op", 64'(a_dut_op), 64'(init_fp_operation));
    chk("rst_fail", 64'(a_fail), 64'(0));
    chk("rst_pass_count", 64'(a_pass_count), 64'(0));
    reset = 1'b1;
    step();
    chk("rst_vec_ready", 64'(a_vec_ready), 64'(1));
    chk("rst_done", 64'(a_done), 64'(0));
    chk("rst_dut_enable", 64'(a_dut_enable), 64'(0));
    chk("rst_dut_fmt", 64'(a_dut_fmt), 64'(0));

    // Stray result with nothing outstanding
    dut_ready = 1'b1; dut_result = 32'h12345678; dut_flags = 5'h03;
    step();
    dut_ready = 1'b0;
    chk("proto_err", 64'(a_proto_err), 64'(1));
    chk("proto_fail", 64'(a_fail), 64'(1));
    chk("proto_fail_count", 64'(a_fail_count), 64'(1));
    chk("proto_err_ref", 64'(a_err_ref), 64'(0));
    chk("proto_err_calc", 64'(a_err_calc), 64'h12345678);
    chk("proto_err_fcalc", 64'(a_err_fcalc), 64'h03);
    chk("proto_halt_ready", 64'(a_vec_ready), 64'(0));
    chk("proto_nostop_ready", 64'(b_vec_ready), 64'(1));

    do_clear();
    chk("clr_fail", 64'(a_fail), 64'(0));
    chk("clr_fail_count", 64'(a_fail_count), 64'(0));
    chk("clr_proto", 64'(a_proto_err), 64'(0));
    chk("clr_err_calc", 64'(a_err_calc), 64'(0));
    chk("clr_vec_ready", 64'(a_vec_ready), 64'(1));

    // Eight fp_add rne vectors, latency 3
    sel_b = 1'b0; fpu_lat = 3; fpu_on = 1'b1;
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 5'h00, 32'h40000000, 5'h00, 1'b0);
    send(32'h40000000, 32'h40400000, 32'h40A00000, 5'h00, 32'h40A00000, 5'h00, 1'b0);
    send(32'h3F800000, 32'hBF800000, 32'h00000000, 5'h00, 32'h00000000, 5'h00, 1'b0);
    send(32'h3FC00000, 32'h3FC00000, 32'h40400000, 5'h00, 32'h40400000, 5'h00, 1'b0);
    send(32'h7F800000, 32'h3F800000, 32'h7F800000, 5'h00, 32'h7F800000, 5'h00, 1'b0);
    send(32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 32'h7FC00000, 5'h10, 1'b0);
    send(32'h3F800000, 32'h33800000, 32'h3F800000, 5'h01, 32'h3F800000, 5'h01, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'h05, 32'h7F800000, 5'h05, 1'b1);
    wait_done("add8_done");
    chk("add8_pass", 64'(a_pass_count), 64'(8));
    chk("add8_fail", 64'(a_fail), 64'(0));
    chk("add8_fail_count", 64'(a_fail_count), 64'(0));
    chk("add8_ready_done", 64'(a_vec_ready), 64'(0));
    chk("add8_data1_hold", 64'(a_dut_data1), 64'h7F7FFFFF);
    chk("add8_op_idle", 64'(a_dut_op), 64'(init_fp_operation));
    chk("add8_b_pass", 64'(b_pass_count), 64'(8));

    // Single-ulp mismatch halts instance a
    do_clear();
    fpu_on = 1'b1;
    send(32'h3F000000, 32'h3F000000, 32'h3F800000, 5'h00, 32'h3F800001, 5'h00, 1'b1);
    w = 0;
    while (!a_fail && w < 50) begin step(); w++; end
    chk("mis_fail", 64'(a_fail), 64'(1));
    chk("mis_err_calc", 64'(a_err_calc), 64'h3F800001);
    chk("mis_err_ref", 64'(a_err_ref), 64'h3F800000);
    chk("mis_err_a", 64'(a_err_a), 64'h3F000000);
    chk("mis_pass", 64'(a_pass_count), 64'(0));
    chk("mis_proto", 64'(a_proto_err), 64'(0));
    step();
    chk("mis_halt_ready", 64'(a_vec_ready), 64'(0));
    chk("mis_not_done", 64'(a_done), 64'(0));
    fpu_on = 1'b0;
    dut_ready = 1'b1; dut_result = 32'h0; dut_flags = 5'h0;
    step();
    dut_ready = 1'b0;
    step();
    chk("halt_ignore_count", 64'(a_fail_count), 64'(1));
    chk("halt_ignore_capture", 64'(a_err_calc), 64'h3F800001);
    chk("halt_ignore_proto", 64'(a_proto_err), 64'(0));

    // Canonical NaN vs NaN with sign/payload: pass
    do_clear();
    fpu_on = 1'b1;
    send(32'h7F800000, 32'hFF800000, 32'hFFC00001, 5'h10, 32'h7FC00000, 5'h10, 1'b1);
    wait_done("nan_done");
    chk("nan_pass", 64'(a_pass_count), 64'(1));
    chk("nan_fail", 64'(a_fail), 64'(0));

    // Stalled DUT: DEPTH accepts then back-pressure until first pop
    do_clear();
    vec_data1 = 32'h40000000; vec_data2 = 32'h40000000; vec_data3 = '0;
    vec_op = init_fp_operation; vec_op.fadd = 1'b1;
    vec_result = 32'h40800000; vec_flags = 5'h00; vec_last = 1'b0; vec_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_vec_ready) acc++;
      step();
    end
    chk("stall_accepts", 64'(acc), 64'(4));
    chk("stall_ready", 64'(a_vec_ready), 64'(0));
    vec_valid = 1'b0;
    dut_ready = 1'b1; dut_result = 32'h40800000; dut_flags = 5'h00;
    step();
    dut_ready = 1'b0;
    chk("stall_ready_after_pop", 64'(a_vec_ready), 64'(1));
    chk("stall_pass", 64'(a_pass_count), 64'(1));

    // Non-halting instance: two mismatches in six vectors
    do_clear();
    sel_b = 1'b1; fpu_lat = 2; fpu_on = 1'b1;
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 5'h00, 32'h40000000, 5'h00, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'h05, 32'h7FC00000, 5'h10, 1'b0);
    send(32'h40000000, 32'h40400000, 32'h40A00000, 5'h00, 32'h40A00000, 5'h00, 1'b0);
    send(32'h3F800000, 32'hBF800000, 32'h00000000, 5'h00, 32'h00000000, 5'h00, 1'b0);
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 5'h00, 32'h40000000, 5'h01, 1'b0);
    send(32'h3FC00000, 32'h3FC00000, 32'h40400000, 5'h00, 32'h40400000, 5'h00, 1'b1);
    wait_done("nostop_done");
    chk("nostop_pass", 64'(b_pass_count), 64'(4));
    chk("nostop_fail_count", 64'(b_fail_count), 64'(2));
    chk("nostop_fail", 64'(b_fail), 64'(1));
    chk("nostop_err_a", 64'(b_err_a), 64'h7F7FFFFF);
    chk("nostop_err_ref", 64'(b_err_ref), 64'h7F800000);
    chk("nostop_err_calc", 64'(b_err_calc), 64'h7FC00000);
    chk("nostop_err_fref", 64'(b_err_fref), 64'h05);
    chk("nostop_err_fcalc", 64'(b_err_fcalc), 64'h10);
    chk("nostop_proto", 64'(b_proto_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
